// File: rtl/fb_port_arbiter.sv
// Frame-buffer BRAM port arbiter: display reads have priority, tracker writes are
// forced through after MAX_WAIT denied cycles. All BRAM controls are registered.
module fb_port_arbiter #(
  parameter int AW       = 17,
  parameter int DW       = 24,
  parameter int MAX_WAIT = 8
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  input  logic [DW-1:0] bram_dout,
  output logic [15:0]   rd_stall_cnt
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FORCE} state_t;

  localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

  state_t        state_reg;
  logic [7:0]    wait_cnt_reg;
  logic [15:0]   rd_stall_cnt_reg;
  logic          bram_en_reg;
  logic          bram_we_reg;
  logic [AW-1:0] bram_addr_reg;
  logic [DW-1:0] bram_din_reg;
  logic          rd_valid_reg;
  logic          force_wr;
  logic          rd_gnt_next;
  logic          wr_gnt_next;

  // Grants are combinational so a requester can transfer in the cycle it asks.
  always_comb begin
    force_wr    = (wait_cnt_reg == MAX_WAIT_L);
    rd_gnt_next = 1'b0;
    wr_gnt_next = 1'b0;
    if (nRESET) begin
      if (force_wr && wr_req) begin
        wr_gnt_next = 1'b1;
      end else if (rd_req) begin
        rd_gnt_next = 1'b1;
      end else begin
        wr_gnt_next = wr_req;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_reg        <= IDLE;
      wait_cnt_reg     <= 8'd0;
      rd_stall_cnt_reg <= 16'd0;
      bram_en_reg      <= 1'b0;
      bram_we_reg      <= 1'b0;
      bram_addr_reg    <= '0;
      bram_din_reg     <= '0;
      rd_valid_reg     <= 1'b0;
    end else begin
      if (rd_gnt_next) begin
        state_reg     <= READ;
        bram_en_reg   <= 1'b1;
        bram_we_reg   <= 1'b0;
        bram_addr_reg <= rd_addr;
      end else if (wr_gnt_next) begin
        state_reg     <= force_wr ? FORCE : WRITE;
        bram_en_reg   <= 1'b1;
        bram_we_reg   <= 1'b1;
        bram_addr_reg <= wr_addr;
        bram_din_reg  <= wr_data;
      end else begin
        state_reg   <= IDLE;
        bram_en_reg <= 1'b0;
        bram_we_reg <= 1'b0;
      end

      // The BRAM returns data one cycle after the registered read is presented.
      rd_valid_reg <= (state_reg == READ);

      if (wr_gnt_next || !wr_req) begin
        wait_cnt_reg <= 8'd0;
      end else if (wait_cnt_reg != MAX_WAIT_L) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end

      if (rd_req && !rd_gnt_next && (rd_stall_cnt_reg != 16'hFFFF)) begin
        rd_stall_cnt_reg <= rd_stall_cnt_reg + 16'd1;
      end
    end
  end

  assign rd_gnt       = rd_gnt_next;
  assign wr_gnt       = wr_gnt_next;
  assign bram_en      = bram_en_reg;
  assign bram_we      = bram_we_reg;
  assign bram_addr    = bram_addr_reg;
  assign bram_din     = bram_din_reg;
  assign rd_valid     = rd_valid_reg;
  assign rd_data      = bram_dout;
  assign rd_stall_cnt = rd_stall_cnt_reg;

endmodule
